dpi_stream_sequencer: RTL and testbench

- Front-end controller that drives a bank of NUM_REGEX per-regex DFA matcher wrappers sharing one character bus.
- Accepts packets as a byte stream, tracks which stream IDs have been seen, and issues load_state / new_stream_id ahead of each packet.
- Paces characters so they reach each DFA only after its state restore completes, then asserts eop with a per-stream enable mask once the DFA pipeline has drained.
- Sits between the packet-input FIFO and the matcher wrappers.

---
 rtl/dpi_stream_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_dpi_stream_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpi_stream_sequencer.sv
// dpi_stream_sequencer
// Front-end controller for a bank of per-regex DFA matcher wrappers sharing a
// single character bus. Each packet arrives as a header beat (s_sop) followed
// by payload bytes. For each packet the block:
//   - issues a one-cycle state-restore pulse (m_load_state);
//   - holds off characters until the wrappers have finished restoring state;
//   - forwards the payload bytes;
//   - waits for the DFA pipeline to drain;
//   - emits a one-cycle m_eop.
//
// Handshake: a beat transfers on every rising clk edge where s_valid && s_ready
// are both high. s_ready is a registered output and never depends
// combinationally on s_valid. A source may raise s_valid at any time. Once
// s_valid is high, the beat fields stay stable until the transfer edge.
//
// Timing relative to the m_load_state cycle T:
//   - WAIT occupies T+1 .. T+LOAD_LAT.
//   - STREAM starts at T+LOAD_LAT+1.
//   - A byte accepted in cycle C appears as m_char/m_char_vld in cycle C+1.
//   - m_eop follows the last m_char_vld cycle by exactly DRAIN_LAT cycles.
//   - For an empty packet, m_eop follows the last WAIT cycle by DRAIN_LAT cycles.

module dpi_stream_sequencer #(
    parameter int NUM_REGEX = 8,
    parameter int LOAD_LAT  = 3,
    parameter int DRAIN_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // packet input
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 s_sop,
    input  logic                 s_last,
    input  logic [5:0]           s_stream_id,
    input  logic [7:0]           s_data,
    // configuration
    input  logic                 cfg_we,
    input  logic [5:0]           cfg_stream_id,
    input  logic [NUM_REGEX-1:0] cfg_enable,
    input  logic                 cfg_clear,
    // matcher-wrapper side
    output logic                 m_load_state,
    output logic                 m_new_stream_id,
    output logic [5:0]           m_stream_id,
    output logic [7:0]           m_char,
    output logic                 m_char_vld,
    output logic                 m_eop,
    output logic [NUM_REGEX-1:0] m_enable,
    // status
    output logic                 busy,
    output logic [15:0]          pkt_cnt,
    output logic [15:0]          drop_cnt,
    output logic [2:0]           dbg_state
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] LOAD_CNT        = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] DRAIN_CNT       = CNT_W'(DRAIN_LAT);
    // An empty packet has no final character cycle, so the last WAIT cycle
    // plays that role. One fewer DRAIN cycle is therefore needed.
    localparam logic [CNT_W-1:0] DRAIN_CNT_EMPTY = CNT_W'(DRAIN_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_EOP    = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [5:0]             id_q;
    logic                   hdr_last_q;
    logic [63:0]            seen_q;
    logic [NUM_REGEX-1:0]   enable_tbl [64];

    logic                   accept;
    logic                   hdr_accept;
    logic                   drop_accept;
    logic                   char_accept;

    assign accept      = s_valid && s_ready;
    assign hdr_accept  = accept && (state_q == ST_IDLE) && s_sop;
    assign drop_accept = accept && (state_q == ST_IDLE) && !s_sop;
    // s_sop is deliberately ignored in STREAM: every beat there is payload.
    assign char_accept = accept && (state_q == ST_STREAM);

    assign dbg_state = state_q;

    // Next-state and phase-counter logic for the packet sequencing FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (hdr_accept) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT;
                cnt_d   = LOAD_CNT;
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    if (!hdr_last_q) begin
                        state_d = ST_STREAM;
                    end else if (DRAIN_CNT_EMPTY != '0) begin
                        state_d = ST_DRAIN;
                        cnt_d   = DRAIN_CNT_EMPTY;
                    end else begin
                        state_d = ST_EOP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STREAM: begin
                if (char_accept && s_last) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_CNT;
                end
            end
            ST_DRAIN: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_EOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_EOP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register, with the registered handshake, strobe and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            m_load_state <= 1'b0;
            m_eop      <= 1'b0;
            m_char_vld <= 1'b0;
            m_char     <= '0;
            pkt_cnt    <= '0;
            drop_cnt   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            s_ready      <= (state_d == ST_IDLE) || (state_d == ST_STREAM);
            busy         <= (state_d != ST_IDLE);
            m_load_state <= (state_d == ST_LOAD);
            m_eop        <= (state_d == ST_EOP);
            m_char_vld   <= char_accept;
            if (char_accept) begin
                m_char <= s_data;
            end
            if (state_q == ST_EOP) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (drop_accept && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Per-packet context: stream ID, enable snapshot, new-stream flag, header-last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_q            <= '0;
            hdr_last_q      <= 1'b0;
            m_stream_id     <= '0;
            m_enable        <= '0;
            m_new_stream_id <= 1'b0;
        end else begin
            if (hdr_accept) begin
                id_q        <= s_stream_id;
                hdr_last_q  <= s_last;
                m_stream_id <= s_stream_id;
                // The snapshot is frozen here, so later table writes never
                // disturb a packet that is already in flight.
                m_enable    <= enable_tbl[s_stream_id];
                // A clear in the same cycle empties the table before LOAD.
                m_new_stream_id <= ~seen_q[s_stream_id] | cfg_clear;
            end else if (state_q == ST_LOAD) begin
                m_new_stream_id <= 1'b0;
            end else if (state_q == ST_EOP) begin
                m_stream_id <= '0;
                m_enable    <= '0;
                hdr_last_q  <= 1'b0;
            end
        end
    end

    // Seen-stream table. A clear takes effect first, then the LOAD set is applied.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen_q <= '0;
        end else begin
            if (cfg_clear) begin
                seen_q <= '0;
            end
            if (state_q == ST_LOAD) begin
                seen_q[id_q] <= 1'b1;
            end
        end
    end

    // Per-stream enable table. It resets to all-ones so unconfigured streams run every regex.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                enable_tbl[i] <= '1;
            end
        end else if (cfg_we) begin
            enable_tbl[cfg_stream_id] <= cfg_enable;
        end
    end

    // Both strobes are one-cycle pulses by construction.
    property p_load_pulse;
        @(posedge clk) disable iff (!rst_n) m_load_state |=> !m_load_state;
    endproperty
    assert property (p_load_pulse);

    property p_eop_pulse;
        @(posedge clk) disable iff (!rst_n) m_eop |=> !m_eop;
    endproperty
    assert property (p_eop_pulse);

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Directed testbench for dpi_stream_sequencer, with hand-computed expectations.
// A negedge monitor records the load, char and eop events of each packet.
// A scoreboard queue holds the expected character order.

module tb_dpi_stream_sequencer;

    localparam int NR = 8;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // DUT signals
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_sop = 1'b0;
    logic          s_last = 1'b0;
    logic [5:0]    s_stream_id = '0;
    logic [7:0]    s_data = '0;
    logic          cfg_we = 1'b0;
    logic [5:0]    cfg_stream_id = '0;
    logic [NR-1:0] cfg_enable = '0;
    logic          cfg_clear = 1'b0;
    logic          m_load_state;
    logic          m_new_stream_id;
    logic [5:0]    m_stream_id;
    logic [7:0]    m_char;
    logic          m_char_vld;
    logic          m_eop;
    logic [NR-1:0] m_enable;
    logic          busy;
    logic [15:0]   pkt_cnt;
    logic [15:0]   drop_cnt;
    logic [2:0]    dbg_state;

    dpi_stream_sequencer #(.NUM_REGEX(NR), .LOAD_LAT(3), .DRAIN_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_sop(s_sop), .s_last(s_last),
        .s_stream_id(s_stream_id), .s_data(s_data),
        .cfg_we(cfg_we), .cfg_stream_id(cfg_stream_id), .cfg_enable(cfg_enable),
        .cfg_clear(cfg_clear),
        .m_load_state(m_load_state), .m_new_stream_id(m_new_stream_id),
        .m_stream_id(m_stream_id), .m_char(m_char), .m_char_vld(m_char_vld),
        .m_eop(m_eop), .m_enable(m_enable), .busy(busy),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .dbg_state(dbg_state)
    );

    // scoreboard state
    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pay_q[$];
    int sop_idx = -1;
    bit ignore_chars = 1'b0;

    // monitor records
    int load_cnt = 0, eop_cnt = 0;
    int load_cyc = 0, eop_cyc = 0;
    int first_vld = -1, last_vld = -1, vld_cnt = 0;
    logic load_new = 1'b0;
    logic [5:0] load_id = '0, eop_id = '0;
    logic [NR-1:0] load_en = '0, eop_en = '0;
    logic sr_hist [4096];
    int exp_pkts = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // monitor: sample outputs on the falling edge
    always @(negedge clk) begin
        sr_hist[cyc % 4096] = s_ready;
        if (rst_n) begin
            if (m_load_state) begin
                load_cnt++;
                load_cyc = cyc;
                load_new = m_new_stream_id;
                load_id  = m_stream_id;
                load_en  = m_enable;
                check("busy_at_load", {63'd0, busy}, 64'd1);
            end
            if (m_char_vld) begin
                vld_cnt++;
                if (first_vld < 0) first_vld = cyc;
                last_vld = cyc;
                if (!ignore_chars) begin
                    if (exp_q.size() == 0) check("extra_char", 64'(exp_q.size()), 64'd1);
                    else check("char", {56'd0, m_char}, {56'd0, exp_q.pop_front()});
                end
            end
            if (m_eop) begin
                eop_cnt++;
                eop_cyc = cyc;
                eop_id  = m_stream_id;
                eop_en  = m_enable;
                check("ready_in_eop", {63'd0, s_ready}, 64'd0);
                for (int k = 0; k < 4; k++)
                    check("ready_in_load_wait", {63'd0, sr_hist[(load_cyc + k) % 4096]}, 64'd0);
                for (int k = 1; k < 4; k++)
                    check("ready_in_drain", {63'd0, sr_hist[(eop_cyc - k) % 4096]}, 64'd0);
            end
        end
    end

    // driver: present one beat and hold it until it is accepted
    task automatic beat(input logic sop, input logic last, input logic [5:0] id,
                        input logic [7:0] d, input bit push);
        int budget = 50;
        bit ok = 1'b0;
        s_valid = 1'b1; s_sop = sop; s_last = last; s_stream_id = id; s_data = d;
        while (!ok && budget > 0) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            budget--;
        end
        check("beat_accept", {63'd0, ok}, 64'd1);
        if (ok && push) exp_q.push_back(d);
        s_valid = 1'b0; s_sop = 1'b0; s_last = 1'b0;
    endtask

    task automatic start_pkt();
        first_vld = -1; last_vld = -1; vld_cnt = 0;
    endtask

    // header followed by the bytes in pay_q; gap idle cycles between payload beats
    task automatic send_packet(input logic [5:0] id, input int gap);
        int n = pay_q.size();
        start_pkt();
        beat(1'b1, n == 0, id, 8'h00, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (gap > 0 && i > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            beat(i == sop_idx, i == n - 1, id, pay_q[i], 1'b1);
        end
    endtask

    task automatic wait_eop(input int prev);
        int budget = 80;
        while (eop_cnt == prev && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check("eop_seen", 64'(eop_cnt - prev), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        exp_pkts++;
    endtask

    task automatic cfg_write(input logic [5:0] id, input logic [NR-1:0] en);
        cfg_we = 1'b1; cfg_stream_id = id; cfg_enable = en;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev, loads_before;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", {63'd0, s_ready}, 64'd0);
        check("rst_strobes", {61'd0, m_load_state, m_eop, m_char_vld}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_counters", {32'd0, pkt_cnt, drop_cnt}, 64'd0);
        check("rst_m_enable", {56'd0, m_enable}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // packet 1: id 5, "ABC"
        prev = eop_cnt;
        pay_q = '{8'h41, 8'h42, 8'h43};
        send_packet(6'd5, 0);
        wait_eop(prev);
        check("p1_new", {63'd0, load_new}, 64'd1);
        check("p1_id", {58'd0, load_id}, 64'd5);
        check("p1_en_load", {56'd0, load_en}, 64'hFF);
        check("p1_en_eop", {56'd0, eop_en}, 64'hFF);
        check("p1_first_spacing", {63'd0, (first_vld - load_cyc) >= 4}, 64'd1);
        check("p1_drain", 64'(eop_cyc - last_vld), 64'd4);
        check("p1_nchar", 64'(vld_cnt), 64'd3);
        check("p1_pkt_cnt", {48'd0, pkt_cnt}, 64'd1);
        check("p1_busy_idle", {63'd0, busy}, 64'd0);

        // packet 2: id 5 again, already seen
        prev = eop_cnt;
        pay_q = '{8'h78, 8'h79};
        send_packet(6'd5, 0);
        wait_eop(prev);
        check("p2_new", {63'd0, load_new}, 64'd0);

        // clear the seen table; id 5 becomes new again
        cfg_clear = 1'b1;
        @(posedge clk);
        #1;
        cfg_clear = 1'b0;
        prev = eop_cnt;
        pay_q = '{8'h7A};
        send_packet(6'd5, 0);
        wait_eop(prev);
        check("p3_new_after_clear", {63'd0, load_new}, 64'd1);
        check("p3_pkt_cnt", {48'd0, pkt_cnt}, 64'd3);

        // enable table: id 9 = 0x0A, rewritten mid-packet
        cfg_write(6'd9, 8'h0A);
        prev = eop_cnt;
        pay_q = '{8'h10, 8'h11, 8'h12, 8'h13};
        fork
            send_packet(6'd9, 0);
            begin
                repeat (7) @(posedge clk);
                #1;
                cfg_write(6'd9, 8'h00);
            end
        join
        wait_eop(prev);
        check("p4_en_load", {56'd0, load_en}, 64'h0A);
        check("p4_en_eop", {56'd0, eop_en}, 64'h0A);
        check("p4_id_eop", {58'd0, eop_id}, 64'd9);

        // mid-packet write now visible; back-to-back writes, last one wins
        cfg_write(6'd12, 8'h11);
        cfg_write(6'd12, 8'h22);
        prev = eop_cnt;
        pay_q = '{8'h20};
        send_packet(6'd9, 0);
        wait_eop(prev);
        check("p5_en_id9", {56'd0, load_en}, 64'h00);
        prev = eop_cnt;
        pay_q = '{8'h21};
        send_packet(6'd12, 0);
        wait_eop(prev);
        check("p6_en_last_write", {56'd0, load_en}, 64'h22);

        // empty packet on id 7
        prev = eop_cnt;
        pay_q.delete();
        send_packet(6'd7, 0);
        wait_eop(prev);
        check("empty_nchar", 64'(vld_cnt), 64'd0);
        check("empty_eop_delay", 64'(eop_cyc - load_cyc), 64'd7);
        check("empty_pkt_cnt", {48'd0, pkt_cnt}, 64'(exp_pkts));

        // three non-sop beats in IDLE are dropped
        loads_before = load_cnt;
        for (int i = 0; i < 3; i++) beat(1'b0, i == 2, 6'd3, 8'(8'hE0 + i), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("drop_cnt", {48'd0, drop_cnt}, 64'd3);
        check("drop_no_load", 64'(load_cnt - loads_before), 64'd0);

        // payload with gaps; one beat carries s_sop and must still count as data
        prev = eop_cnt;
        pay_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        sop_idx = 2;
        send_packet(6'd33, 2);
        sop_idx = -1;
        wait_eop(prev);
        check("gap_nchar", 64'(vld_cnt), 64'd5);
        check("gap_drain", 64'(eop_cyc - last_vld), 64'd4);
        check("gap_queue_empty", 64'(exp_q.size()), 64'd0);
        check("gap_pkt_cnt", {48'd0, pkt_cnt}, 64'(exp_pkts));

        // reset while streaming
        ignore_chars = 1'b1;
        start_pkt();
        beat(1'b1, 1'b0, 6'd5, 8'h00, 1'b0);
        beat(1'b0, 1'b0, 6'd5, 8'h51, 1'b0);
        s_valid = 1'b1; s_data = 8'h52;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_strobes", {60'd0, m_load_state, m_eop, m_char_vld, m_new_stream_id}, 64'd0);
        check("mid_rst_ready_busy", {62'd0, s_ready, busy}, 64'd0);
        check("mid_rst_data", {42'd0, m_stream_id, m_char, m_enable}, 64'd0);
        check("mid_rst_counters", {32'd0, pkt_cnt, drop_cnt}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev = eop_cnt;
        repeat (15) @(posedge clk);
        #1;
        check("mid_rst_no_eop", 64'(eop_cnt - prev), 64'd0);
        ignore_chars = 1'b0;
        exp_q.delete();
        exp_pkts = 0;

        // tables reinitialised by the reset
        prev = eop_cnt;
        pay_q = '{8'h52};
        send_packet(6'd5, 0);
        wait_eop(prev);
        check("post_rst_new", {63'd0, load_new}, 64'd1);
        prev = eop_cnt;
        pay_q = '{8'h53};
        send_packet(6'd9, 0);
        wait_eop(prev);
        check("post_rst_en", {56'd0, load_en}, 64'hFF);
        check("post_rst_pkt_cnt", {48'd0, pkt_cnt}, 64'(exp_pkts));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
